// File: rtl/pattern_search_ctrl_pkg.sv
// Shared types and default widths for the pattern search sequencer.
package pattern_search_ctrl_pkg;

    localparam int PSA_ADDR_W = 8;
    localparam int PSA_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CMP   = 2'd2,
        S_DONE  = 2'd3
    } psa_state_e;

endpackage

// File: rtl/pattern_search_ctrl_if.sv
// Host control/status plus both BRAM A-port buses; master = search controller side.
interface pattern_search_ctrl_if
    import pattern_search_ctrl_pkg::*;
#(
    parameter int ADDR_W = PSA_ADDR_W,
    parameter int DATA_W = PSA_DATA_W
);
    localparam int LEN_W = ADDR_W + 1;

    logic              start;
    logic              abort;
    logic [LEN_W-1:0]  data_len;
    logic [LEN_W-1:0]  pat_len;
    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W-1:0] match_addr;

    logic              data_ena;
    logic              data_wea;
    logic [ADDR_W-1:0] data_addra;
    logic [DATA_W-1:0] data_douta;

    logic              pat_ena;
    logic              pat_wea;
    logic [ADDR_W-1:0] pat_addra;
    logic [DATA_W-1:0] pat_douta;

    modport master (
        input  start, abort, data_len, pat_len, data_douta, pat_douta,
        output busy, done, found, match_addr,
               data_ena, data_wea, data_addra, pat_ena, pat_wea, pat_addra
    );

    modport slave (
        output start, abort, data_len, pat_len, data_douta, pat_douta,
        input  busy, done, found, match_addr,
               data_ena, data_wea, data_addra, pat_ena, pat_wea, pat_addra
    );

endinterface

// File: rtl/pattern_search_ctrl.sv
// Naive substring search of the pattern BRAM within the data BRAM; reports first match base.
// Latency: 2 cycles per byte compare, done after 2*compares+1 edges counting the start edge.
// Backpressure: none; start is ignored while busy, abort cancels without a done pulse.
module pattern_search_ctrl
    import pattern_search_ctrl_pkg::*;
#(
    parameter int ADDR_W = PSA_ADDR_W,
    parameter int DATA_W = PSA_DATA_W
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    pattern_search_ctrl_if.master bus
);
    localparam int LEN_W = ADDR_W + 1;

    psa_state_e        state_q, state_d;
    logic [LEN_W-1:0]  base_q, base_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  dlen_q, dlen_d;
    logic [LEN_W-1:0]  plen_q, plen_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] match_q, match_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;

    logic [DATA_W-1:0] data_byte, pat_byte;
    logic              start_ok, len_bad, byte_eq, last_idx, base_over;
    logic [LEN_W-1:0]  base_inc, last_base;

    assign data_byte = bus.data_douta;
    assign pat_byte  = bus.pat_douta;

    // abort wins over a simultaneous start in IDLE
    assign start_ok  = bus.start && !bus.abort;
    assign len_bad   = (bus.pat_len == '0) || (bus.pat_len > bus.data_len);
    assign byte_eq   = (data_byte == pat_byte);
    assign last_idx  = (idx_q == plen_q - LEN_W'(1));
    assign base_inc  = base_q + LEN_W'(1);
    // only consulted in CMP, where plen_q <= dlen_q is guaranteed
    assign last_base = dlen_q - plen_q;
    assign base_over = (base_inc > last_base);

    always_comb begin
        state_d = state_q;
        found_d = found_q;
        match_d = match_q;
        dlen_d  = dlen_q;
        plen_d  = plen_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    dlen_d  = bus.data_len;
                    plen_d  = bus.pat_len;
                    found_d = 1'b0;
                    match_d = '0;
                    state_d = len_bad ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_CMP;
            S_CMP: begin
                if (byte_eq && last_idx) begin
                    found_d = 1'b1;
                    match_d = base_q[ADDR_W-1:0];
                    state_d = S_DONE;
                end else if (byte_eq) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = base_over ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            found_d = 1'b0;
            match_d = '0;
        end
    end

    always_comb begin
        base_d  = base_q;
        idx_d   = idx_q;
        daddr_d = daddr_q;
        paddr_d = paddr_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    base_d = '0;
                    idx_d  = '0;
                end
            end
            S_CMP: begin
                if (byte_eq && !last_idx) begin
                    idx_d = idx_q + LEN_W'(1);
                end else if (!byte_eq) begin
                    base_d = base_inc;
                    idx_d  = '0;
                end
            end
            default: ;
        endcase
        // Addresses are loaded only on entry to FETCH so they hold between fetches
        // and never show the out-of-range base left behind by the final mismatch.
        if (state_d == S_FETCH) begin
            daddr_d = base_d[ADDR_W-1:0] + idx_d[ADDR_W-1:0];
            paddr_d = idx_d[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            base_q  <= '0;
            idx_q   <= '0;
            dlen_q  <= '0;
            plen_q  <= '0;
            found_q <= 1'b0;
            match_q <= '0;
            daddr_q <= '0;
            paddr_q <= '0;
        end else begin
            base_q  <= base_d;
            idx_q   <= idx_d;
            dlen_q  <= dlen_d;
            plen_q  <= plen_d;
            found_q <= found_d;
            match_q <= match_d;
            daddr_q <= daddr_d;
            paddr_q <= paddr_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.found      = found_q;
    assign bus.match_addr = match_q;
    assign bus.data_ena   = (state_q == S_FETCH);
    assign bus.pat_ena    = (state_q == S_FETCH);
    assign bus.data_wea   = 1'b0;
    assign bus.pat_wea    = 1'b0;
    assign bus.data_addra = daddr_q;
    assign bus.pat_addra  = paddr_q;

endmodule

// File: tb/tb_pattern_search_ctrl.sv
// Bench for pattern_search_ctrl: directed table, abort/reset sequences, randomized model check.
module tb_pattern_search_ctrl;

    logic clka = 1'b0;
    logic rsta_n = 1'b1;

    always #5 clka = ~clka;

    pattern_search_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    pattern_search_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clka   (clka),
        .rsta_n (rsta_n),
        .bus    (bus.master)
    );

    logic [7:0] dmem [256];
    logic [7:0] pmem [256];

    always @(posedge clka) begin
        if (bus.data_ena) bus.data_douta <= dmem[bus.data_addra];
        if (bus.pat_ena)  bus.pat_douta  <= pmem[bus.pat_addra];
    end

    int total = 0;
    int bad   = 0;
    int done_cnt, ena_cnt, busy_drop, max_addr, wrapped, edges;

    typedef struct {
        int          dlen;
        int          plen;
        logic [31:0] p;      // pattern bytes, byte 0 in [7:0]
        int          e_found;
        int          e_match;
        int          e_edges;
        int          e_ena;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ramp_data();
        for (int i = 0; i < 256; i++) dmem[i] = 8'(i);
    endtask

    // Behavioural reference: brute force over every base, counting byte compares.
    task automatic model(input int dlen, input int plen,
                         output int f, output int m, output int c);
        f = 0; m = 0; c = 0;
        if (plen == 0 || plen > dlen) return;
        for (int b = 0; b <= dlen - plen && f == 0; b++) begin
            bit ok = 1'b1;
            for (int i = 0; i < plen && ok; i++) begin
                c++;
                if (dmem[b + i] != pmem[i]) ok = 1'b0;
            end
            if (ok) begin
                f = 1;
                m = b;
            end
        end
    endtask

    // Runs one search; edges counts posedges from the start edge (=1) to the one that raises done.
    task automatic run(input int dlen, input int plen, input bit poke);
        logic [7:0] prev;
        bit seen;
        prev = 8'h00; seen = 1'b0;
        done_cnt = 0; ena_cnt = 0; busy_drop = 0; max_addr = -1; wrapped = 0; edges = 0;
        @(negedge clka);
        bus.data_len = 9'(dlen);
        bus.pat_len  = 9'(plen);
        bus.start    = 1'b1;
        do begin
            @(posedge clka); #1;
            edges++;
            bus.start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (bus.done) done_cnt++;
            if (!bus.busy) busy_drop++;
            if (bus.data_ena || bus.pat_ena) ena_cnt++;
            if (bus.data_ena) begin
                if (seen && prev == 8'hFF && bus.data_addra == 8'h00) wrapped = 1;
                if (int'(bus.data_addra) > max_addr) max_addr = int'(bus.data_addra);
                prev = bus.data_addra;
                seen = 1'b1;
            end
        end while (!bus.done && edges < 2000);
        bus.start = 1'b0;
        if (!bus.done) check("done_timeout", 0, 1);
        repeat (3) begin
            @(posedge clka); #1;
            if (bus.done) done_cnt++;
        end
        check("idle_after_done", int'(bus.busy), 0);
    endtask

    initial begin
        int f, m, c, dlen, plen;
        bus.start = 1'b0; bus.abort = 1'b0; bus.data_len = '0; bus.pat_len = '0;
        ramp_data();
        for (int i = 0; i < 256; i++) pmem[i] = 8'h00;

        #2 rsta_n = 1'b0;
        #3;
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_done",  int'(bus.done), 0);
        check("rst_found", int'(bus.found), 0);
        check("rst_match", int'(bus.match_addr), 0);
        check("rst_ena",   int'({bus.data_ena, bus.pat_ena}), 0);
        check("rst_addr",  int'({bus.data_addra, bus.pat_addra}), 0);
        check("rst_wea",   int'({bus.data_wea, bus.pat_wea}), 0);
        repeat (2) @(negedge clka);
        rsta_n = 1'b1;

        vecs[0] = '{256, 3, 32'h00070605, 1, 5,   17,  8};
        vecs[1] = '{256, 2, 32'h00000507, 0, 0,   513, 256};
        vecs[2] = '{8,   0, 32'h00000000, 0, 0,   1,   0};
        vecs[3] = '{8,   9, 32'h00000000, 0, 0,   1,   0};
        vecs[4] = '{256, 2, 32'h0000FFFE, 1, 254, 513, 256};
        vecs[5] = '{3,   3, 32'h00020100, 1, 0,   7,   3};
        vecs[6] = '{4,   1, 32'h00000003, 1, 3,   9,   4};
        vecs[7] = '{2,   2, 32'h00000500, 0, 0,   5,   2};
        vecs[8] = '{256, 1, 32'h000000FF, 1, 255, 513, 256};
        vecs[9] = '{255, 1, 32'h000000FF, 0, 0,   511, 255};

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 4; i++) pmem[i] = vecs[v].p[i*8 +: 8];
            run(vecs[v].dlen, vecs[v].plen, 1'b0);
            check($sformatf("v%0d_found", v), int'(bus.found), vecs[v].e_found);
            check($sformatf("v%0d_match", v), int'(bus.match_addr), vecs[v].e_match);
            check($sformatf("v%0d_edges", v), edges, vecs[v].e_edges);
            check($sformatf("v%0d_dones", v), done_cnt, 1);
            check($sformatf("v%0d_busy", v), busy_drop, 0);
            check($sformatf("v%0d_ena", v), ena_cnt, vecs[v].e_ena);
            if (v == 4) begin
                check("v4_max_addr", max_addr, 255);
                check("v4_wrap", wrapped, 0);
            end
        end

        // abort during an early CMP, then during the final (matching) CMP
        pmem[0] = 8'h05; pmem[1] = 8'h06; pmem[2] = 8'h07;
        for (int k = 0; k < 2; k++) begin
            @(negedge clka);
            bus.data_len = 9'd256; bus.pat_len = 9'd3; bus.start = 1'b1;
            @(posedge clka); #1;
            bus.start = 1'b0;
            repeat (k == 0 ? 3 : 15) begin
                @(posedge clka); #1;
            end
            check($sformatf("abort%0d_pre_busy", k), int'(bus.busy), 1);
            check($sformatf("abort%0d_pre_ena", k), int'(bus.data_ena), 0);
            bus.abort = 1'b1;
            @(posedge clka); #1;
            bus.abort = 1'b0;
            check($sformatf("abort%0d_busy", k), int'(bus.busy), 0);
            check($sformatf("abort%0d_found", k), int'(bus.found), 0);
            check($sformatf("abort%0d_match", k), int'(bus.match_addr), 0);
            done_cnt = 0;
            repeat (4) begin
                if (bus.done) done_cnt++;
                @(posedge clka); #1;
            end
            check($sformatf("abort%0d_no_done", k), done_cnt, 0);
        end

        // start and abort together in IDLE stays IDLE
        @(negedge clka);
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clka); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_idle", int'(bus.busy), 0);

        // restart after abort, with start pulses while busy
        run(256, 3, 1'b1);
        check("restart_found", int'(bus.found), 1);
        check("restart_match", int'(bus.match_addr), 5);
        check("restart_edges", edges, 17);
        check("restart_dones", done_cnt, 1);

        // reset while idle with found held
        @(negedge clka); #2;
        rsta_n = 1'b0;
        #1;
        check("rst_idle_found", int'(bus.found), 0);
        check("rst_idle_match", int'(bus.match_addr), 0);
        @(negedge clka);
        rsta_n = 1'b1;

        // reset mid-search
        pmem[0] = 8'h07; pmem[1] = 8'h05;
        @(negedge clka);
        bus.data_len = 9'd256; bus.pat_len = 9'd2; bus.start = 1'b1;
        @(posedge clka); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clka);
        #3;
        check("mid_pre_busy", int'(bus.busy), 1);
        rsta_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_ena",  int'({bus.data_ena, bus.pat_ena}), 0);
        check("mid_rst_addr", int'({bus.data_addra, bus.pat_addra}), 0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge clka);
            if (bus.done) done_cnt++;
        end
        rsta_n = 1'b1;
        check("mid_rst_no_done", done_cnt, 0);

        // randomized search over a small alphabet so matches are common
        for (int t = 0; t < 40; t++) begin
            dlen = $urandom_range(1, 48);
            plen = $urandom_range(0, 6);
            for (int i = 0; i < 256; i++) begin
                dmem[i] = 8'($urandom_range(0, 2));
                pmem[i] = 8'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 1) == 1 && plen > 0 && plen <= dlen) begin
                int off;
                off = $urandom_range(0, dlen - plen);
                for (int i = 0; i < plen; i++) pmem[i] = dmem[off + i];
            end
            model(dlen, plen, f, m, c);
            run(dlen, plen, t[0]);
            check($sformatf("r%0d_found", t), int'(bus.found), f);
            check($sformatf("r%0d_match", t), int'(bus.match_addr), m);
            check($sformatf("r%0d_edges", t), edges, 2 * c + 1);
            check($sformatf("r%0d_dones", t), done_cnt, 1);
            check($sformatf("r%0d_ena", t), ena_cnt, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
